shift_reg_univ: RTL and testbench

//   Parametrised universal shift/rotate register with multi-step sequencing.
//   - Accepts a command: operation + step count. Performs one single-bit step per clock.
//   - Reports busy/done status and a registered serial output.
//   - Used wherever a datapath needs variable-amount shifts, rotates or serial streaming.
//   - Replaces fixed 8-bit hold/shift/load registers built from d_ff cells.

---
 rtl/shift_reg_univ_pkg.sv | 19 +
 rtl/shift_reg_univ_if.sv | 25 ++
 rtl/shift_reg_univ_step.sv | 38 +++
 rtl/shift_reg_univ.sv | 92 +++++++++
 tb/tb_shift_reg_univ.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_reg_univ_pkg.sv
// rtl/shift_reg_univ_pkg.sv - op codes and FSM state encoding for the universal shift register
package shift_reg_pkg;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_SRS  = 3'b110;
  localparam logic [2:0] OP_SLS  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_reg_univ_if.sv
// rtl/shift_reg_univ_if.sv - command/status bundle between a controller and the shift register
interface shift_reg_univ_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
);
  logic             start;
  logic [2:0]       op;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] data_in;
  logic             serial_in;
  logic [WIDTH-1:0] data_out;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output start, op, amount, data_in, serial_in,
    input  data_out, serial_out, busy, done
  );

  modport slave (
    input  start, op, amount, data_in, serial_in,
    output data_out, serial_out, busy, done
  );
endinterface

// File: rtl/shift_reg_univ_step.sv
// rtl/shift_reg_univ_step.sv - one single-bit shift/rotate step plus the bit it drops
module shift_step_unit
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [2:0]       op_i,
  input  logic             serial_i,
  output logic [WIDTH-1:0] data_o,
  output logic             drop_o
);

  always_comb begin
    data_o = data_i;
    drop_o = data_i[0];
    case (op_i)
      OP_SRL: data_o = {1'b0, data_i[WIDTH-1:1]};
      OP_SRA: data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
      OP_ROR: data_o = {data_i[0], data_i[WIDTH-1:1]};
      OP_SRS: data_o = {serial_i, data_i[WIDTH-1:1]};
      OP_SLL: begin
        data_o = {data_i[WIDTH-2:0], 1'b0};
        drop_o = data_i[WIDTH-1];
      end
      OP_ROL: begin
        data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
        drop_o = data_i[WIDTH-1];
      end
      OP_SLS: begin
        data_o = {data_i[WIDTH-2:0], serial_i};
        drop_o = data_i[WIDTH-1];
      end
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_reg_univ.sv
// rtl/shift_reg_univ.sv - universal shift/rotate register, one step per clock for N steps
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_reg_univ_if.slave  bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ser_q, ser_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [2:0]       op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_data;
  logic             step_drop;

  shift_step_unit #(.WIDTH(WIDTH)) u_step (
    .data_i   (data_q),
    .op_i     (op_q),
    .serial_i (bus.serial_in),
    .data_o   (step_data),
    .drop_o   (step_drop)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ser_d   = ser_q;
    count_d = count_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start) begin
          op_d = bus.op;
          if (bus.op == OP_LOAD) begin
            data_d  = bus.data_in;
            state_d = ST_DONE;
          end else if (bus.amount == '0) begin
            state_d = ST_DONE;
          end else begin
            count_d = bus.amount;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        data_d  = step_data;
        ser_d   = step_drop;
        count_d = count_q - AMT_W'(1);
        if (count_q == AMT_W'(1)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Status flags are registered copies of the next state, so they track state_q exactly.
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      ser_q   <= 1'b0;
      count_q <= '0;
      op_q    <= OP_LOAD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ser_q   <= ser_d;
      count_q <= count_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.serial_out = ser_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// tb/tb_shift_reg_univ.sv - self-checking bench for shift_reg_univ against an arithmetic model
module tb_shift_reg_univ;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] exp_data = 8'h00;
  logic       exp_ser  = 1'b0;

  shift_reg_univ_if #(.WIDTH(8), .AMT_W(4)) bus ();

  shift_reg_univ #(.WIDTH(8), .AMT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference step on the value as an unsigned integer: halving/doubling and weights.
  function automatic logic [8:0] ref_step(input logic [2:0] o, input logic [7:0] d, input logic s);
    int v, nv, dr;
    v = int'(d);
    nv = v;
    dr = 0;
    case (o)
      3'd1: begin nv = v / 2;                      dr = v % 2;   end
      3'd2: begin nv = (v * 2) % 256;              dr = v / 128; end
      3'd3: begin nv = v / 2 + (v / 128) * 128;    dr = v % 2;   end
      3'd4: begin nv = v / 2 + (v % 2) * 128;      dr = v % 2;   end
      3'd5: begin nv = (v * 2) % 256 + v / 128;    dr = v / 128; end
      3'd6: begin nv = v / 2 + int'(s) * 128;      dr = v % 2;   end
      3'd7: begin nv = (v * 2) % 256 + int'(s);    dr = v / 128; end
      default: begin nv = v; dr = 0; end
    endcase
    return {dr[0], nv[7:0]};
  endfunction

  task automatic issue(input logic [2:0] o, input logic [3:0] amt, input logic [7:0] din);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.op        = o;
    bus.amount    = amt;
    bus.data_in   = din;
    bus.serial_in = 1'($urandom);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (o == 3'd0) exp_data = din;
  endtask

  task automatic step(input logic s, input logic spurious);
    @(negedge clk);
    bus.serial_in = s;
    bus.start     = spurious;
    bus.op        = 3'($urandom);
    bus.amount    = 4'($urandom);
    bus.data_in   = 8'($urandom);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic model_step(input logic [2:0] o, input logic s);
    logic [8:0] r;
    r = ref_step(o, exp_data, s);
    exp_data = r[7:0];
    exp_ser  = r[8];
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.data_out, bus.serial_out, bus.busy, bus.done} !== 11'b0) begin
      errors++;
      $display("FAIL reset_initial: got data=%h ser=%b busy=%b done=%b, want all 0",
               bus.data_out, bus.serial_out, bus.busy, bus.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd0, 4'd0, 8'hFF);
    issue(3'd1, 4'd8, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      model_step(3'd1, 1'b0);
    end
    checks++;
    if (bus.busy !== 1'b1 || bus.data_out !== exp_data) begin
      errors++;
      $display("FAIL reset_midshift_pre: got busy=%b data=%h, want busy=1 data=%h",
               bus.busy, bus.data_out, exp_data);
    end
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_data = 8'h00;
    exp_ser  = 1'b0;
    checks++;
    if ({bus.data_out, bus.serial_out, bus.busy, bus.done} !== 11'b0) begin
      errors++;
      $display("FAIL reset_abort: got data=%h ser=%b busy=%b done=%b, want all 0",
               bus.data_out, bus.serial_out, bus.busy, bus.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_idle_hold: got busy=%b done=%b data=%h, want 0 0 00",
               bus.busy, bus.done, bus.data_out);
    end
  endtask

  task automatic test_load();
    issue(3'd0, 4'd5, 8'hA5);
    checks++;
    if (bus.data_out !== 8'hA5 || bus.done !== 1'b1 || bus.busy !== 1'b0 ||
        bus.serial_out !== exp_ser) begin
      errors++;
      $display("FAIL load: got data=%h done=%b busy=%b ser=%b, want A5 1 0 %b",
               bus.data_out, bus.done, bus.busy, bus.serial_out, exp_ser);
    end
    step(1'b0, 1'b0);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.data_out !== 8'hA5) begin
      errors++;
      $display("FAIL load_after: got done=%b busy=%b data=%h, want 0 0 A5",
               bus.done, bus.busy, bus.data_out);
    end
  endtask

  task automatic test_sra();
    int busy_cycles = 0;
    issue(3'd0, 4'd0, 8'h96);
    issue(3'd3, 4'd3, 8'h00);
    for (int i = 0; i < 3; i++) begin
      if (bus.busy === 1'b1) busy_cycles++;
      step(1'($urandom), 1'b0);
      model_step(3'd3, 1'b0);
    end
    checks++;
    if (bus.data_out !== 8'hF2 || bus.serial_out !== 1'b1 || bus.done !== 1'b1 ||
        bus.busy !== 1'b0 || busy_cycles != 3) begin
      errors++;
      $display("FAIL sra3: got data=%h ser=%b done=%b busy=%b busy_cycles=%0d, want F2 1 1 0 3",
               bus.data_out, bus.serial_out, bus.done, bus.busy, busy_cycles);
    end
  endtask

  task automatic test_rol_wrap();
    int busy_cycles = 0;
    int done_cycles = 0;
    issue(3'd0, 4'd0, 8'h81);
    issue(3'd5, 4'd10, 8'h00);
    for (int i = 0; i < 12; i++) begin
      busy_cycles += int'(bus.busy);
      step(1'($urandom), 1'b0);
      done_cycles += int'(bus.done);
    end
    checks++;
    if (bus.data_out !== 8'h06 || busy_cycles != 10 || done_cycles != 1) begin
      errors++;
      $display("FAIL rol10: got data=%h busy_cycles=%0d done_cycles=%0d, want 06 10 1",
               bus.data_out, busy_cycles, done_cycles);
    end
  endtask

  task automatic test_sls_ignore();
    logic [3:0] bits;
    int done_cycles = 0;
    bits = 4'b1101;
    issue(3'd0, 4'd0, 8'h00);
    issue(3'd7, 4'd4, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(bits[i], (i == 1));
      done_cycles += int'(bus.done);
    end
    checks++;
    if (bus.data_out !== 8'h0B || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL sls4: got data=%h done=%b, want 0B 1", bus.data_out, bus.done);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      done_cycles += int'(bus.done);
    end
    checks++;
    if (done_cycles != 1 || bus.data_out !== 8'h0B || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL sls_single_done: got done_cycles=%0d data=%h busy=%b, want 1 0B 0",
               done_cycles, bus.data_out, bus.busy);
    end
    exp_data = 8'h0B;
    exp_ser  = 1'b0;
  endtask

  task automatic test_back_to_back();
    issue(3'd0, 4'd0, 8'h3C);
    issue(3'd1, 4'd0, 8'h00);
    checks++;
    if (bus.data_out !== 8'h3C || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL srl0: got data=%h done=%b busy=%b, want 3C 1 0",
               bus.data_out, bus.done, bus.busy);
    end
    issue(3'd0, 4'd0, 8'h11);
    checks++;
    if (bus.data_out !== 8'h11 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_load: got data=%h done=%b busy=%b, want 11 1 0",
               bus.data_out, bus.done, bus.busy);
    end
    step(1'b0, 1'b0);
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_clears: got done=%b, want 0", bus.done);
    end
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic [3:0] amt;
    logic [7:0] din;
    logic       s;
    exp_data = bus.data_out;
    for (int c = 0; c < 40; c++) begin
      o   = 3'($urandom);
      amt = 4'($urandom_range(0, 15));
      din = 8'($urandom);
      issue(o, amt, din);
      if (o != 3'd0 && amt != 4'd0) begin
        for (int i = 0; i < int'(amt); i++) begin
          s = 1'($urandom);
          step(s, 1'($urandom_range(0, 3) == 0));
          model_step(o, s);
          checks++;
          if (bus.data_out !== exp_data || bus.serial_out !== exp_ser ||
              bus.busy !== (i < int'(amt) - 1) || bus.done !== (i == int'(amt) - 1)) begin
            errors++;
            $display("FAIL rand_step c=%0d op=%0d i=%0d: got data=%h ser=%b busy=%b done=%b, want data=%h ser=%b",
                     c, o, i, bus.data_out, bus.serial_out, bus.busy, bus.done, exp_data, exp_ser);
          end
        end
      end else begin
        checks++;
        if (bus.data_out !== exp_data || bus.serial_out !== exp_ser ||
            bus.busy !== 1'b0 || bus.done !== 1'b1) begin
          errors++;
          $display("FAIL rand_immediate c=%0d op=%0d: got data=%h ser=%b busy=%b done=%b, want data=%h ser=%b",
                   c, o, bus.data_out, bus.serial_out, bus.busy, bus.done, exp_data, exp_ser);
        end
      end
      if ($urandom_range(0, 1) == 0) begin
        step(1'($urandom), 1'b0);
        checks++;
        if (bus.data_out !== exp_data || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL rand_idle c=%0d: got data=%h done=%b busy=%b, want data=%h 0 0",
                   c, bus.data_out, bus.done, bus.busy, exp_data);
        end
      end
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.op        = 3'd0;
    bus.amount    = 4'd0;
    bus.data_in   = 8'h00;
    bus.serial_in = 1'b0;
    test_reset();
    test_load();
    test_sra();
    test_rol_wrap();
    test_sls_ignore();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
